serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 127 ++++++++++++
 tb/tb_serial_subtractor.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// A start in IDLE captures the operands; busy is high for WIDTH cycles,
// then done pulses for one cycle with diff, bout and ovf valid.
// Results stay registered until the next done pulse or reset.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] diff_q;
    logic [CNT_W-1:0] cnt;
    logic             borrow_q;
    logic             bout_q;
    logic             ovf_q;

    logic             x;
    logic             y;
    logic             d;
    logic             borrow_next;
    logic             last_bit;
    logic             accept;

    // Full-subtractor cell on the current LSBs and the registered borrow.
    always_comb begin
        x           = a_sr[0];
        y           = b_sr[0];
        d           = x ^ y ^ borrow_q;
        borrow_next = (~x & y) | (~(x ^ y) & borrow_q);
        last_bit    = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
        accept      = (state == IDLE) && start;
    end

    // State register; reset always returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the busy/done outputs decoded from the state.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial shifting and final result registration.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            borrow_q <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_sr     <= a;
            b_sr     <= b;
            borrow_q <= bin;
            cnt      <= '0;
        end else if (state == SHIFT) begin
            a_sr     <= a_sr >> 1;
            b_sr     <= b_sr >> 1;
            res_sr   <= {d, res_sr[WIDTH-1:1]};
            borrow_q <= borrow_next;
            cnt      <= cnt + CNT_W'(1);
            if (last_bit) begin
                diff_q <= {d, res_sr[WIDTH-1:1]};
                bout_q <= borrow_next;
                ovf_q  <= (x ^ y) & (x ^ d);
            end
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=16.
// Expected results come from a plain-arithmetic model and are queued at
// start; monitors pop and compare whenever done pulses.
module tb_serial_subtractor;

    localparam int W8  = 8;
    localparam int W16 = 16;

    typedef struct {
        logic [63:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;

    logic          rst8, start8, bin8, busy8, done8, bout8, ovf8;
    logic [W8-1:0] a8, b8, diff8;

    logic           rst16, start16, bin16, busy16, done16, bout16, ovf16;
    logic [W16-1:0] a16, b16, diff16;

    int   checks = 0;
    int   errors = 0;
    exp_t q8[$];
    exp_t q16[$];
    exp_t mon8;
    exp_t mon16;

    serial_subtractor #(.WIDTH(W8), .CNT_W(5)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    serial_subtractor #(.WIDTH(W16), .CNT_W(5)) dut16 (
        .clk(clk), .rst(rst16), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .ovf(ovf16)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference: exact integer arithmetic, then reduce modulo 2^w.
    function automatic exp_t model(input int w, input logic [31:0] av,
                                   input logic [31:0] bv, input logic bi);
        exp_t   e;
        longint m    = longint'(1) << w;
        longint ua   = longint'(av) % m;
        longint ub   = longint'(bv) % m;
        longint full = ua - ub - longint'(bi);
        longint sa   = (ua >= m / 2) ? ua - m : ua;
        longint sb   = (ub >= m / 2) ? ub - m : ub;
        longint r    = sa - sb - longint'(bi);
        longint dm   = (full < 0) ? full + m : full;
        e.diff = 64'(dm);
        e.bout = (full < 0);
        e.ovf  = (r < -(m / 2)) || (r >= m / 2);
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor for the 8-bit instance: compare on every done pulse.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done8: got done=1, required no pending operation");
            end else begin
                mon8 = q8.pop_front();
                checkOutput("diff8", 64'(diff8), mon8.diff);
                checkOutput("bout8", 64'(bout8), 64'(mon8.bout));
                checkOutput("ovf8",  64'(ovf8),  64'(mon8.ovf));
            end
        end
    end

    // Monitor for the 16-bit instance.
    always @(negedge clk) begin
        if (done16 === 1'b1) begin
            if (q16.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done16: got done=1, required no pending operation");
            end else begin
                mon16 = q16.pop_front();
                checkOutput("diff16", 64'(diff16), mon16.diff);
                checkOutput("bout16", 64'(bout16), 64'(mon16.bout));
                checkOutput("ovf16",  64'(ovf16),  64'(mon16.ovf));
            end
        end
    end

    task automatic checkResetState8(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy8), 64'd0);
        checkOutput({tag, "_done"}, 64'(done8), 64'd0);
        checkOutput({tag, "_diff"}, 64'(diff8), 64'd0);
        checkOutput({tag, "_bout"}, 64'(bout8), 64'd0);
        checkOutput({tag, "_ovf"},  64'(ovf8),  64'd0);
    endtask

    // One 8-bit operation: optional ignored start at SHIFT cycle glitch_at,
    // optional reset at SHIFT cycle rst_at (0 disables either).
    task automatic applyStimulus(input logic [W8-1:0] av, input logic [W8-1:0] bv,
                                 input logic bi, input int glitch_at, input int rst_at);
        int lat;
        @(negedge clk);
        a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
        q8.push_back(model(W8, 32'(av), 32'(bv), bi));
        @(negedge clk);
        start8 = 1'b0;
        a8 = W8'($urandom); b8 = W8'($urandom); bin8 = 1'($urandom);
        lat = 1;
        while (done8 !== 1'b1 && lat <= W8 + 4) begin
            if (lat == rst_at) begin
                rst8 = 1'b1;
                q8.delete(q8.size() - 1);
                @(negedge clk);
                rst8 = 1'b0;
                checkResetState8("rst_mid");
                repeat (W8 + 4) begin
                    @(negedge clk);
                    checkOutput("no_done_after_rst", 64'(done8), 64'd0);
                end
                return;
            end
            checkOutput("busy8", 64'(busy8), 64'd1);
            if (lat == glitch_at) begin
                start8 = 1'b1; a8 = av ^ 8'h5C; b8 = bv ^ 8'hA3; bin8 = ~bi;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start8 = 1'b0;
        checkOutput("latency8", 64'(lat), 64'(W8 + 1));
        checkOutput("busy_in_done8", 64'(busy8), 64'd0);
    endtask

    // One 16-bit operation with latency check.
    task automatic applyStimulusWide(input logic [W16-1:0] av, input logic [W16-1:0] bv,
                                     input logic bi);
        int lat;
        @(negedge clk);
        a16 = av; b16 = bv; bin16 = bi; start16 = 1'b1;
        q16.push_back(model(W16, 32'(av), 32'(bv), bi));
        @(negedge clk);
        start16 = 1'b0;
        a16 = W16'($urandom); b16 = W16'($urandom); bin16 = 1'($urandom);
        lat = 1;
        while (done16 !== 1'b1 && lat <= W16 + 4) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency16", 64'(lat), 64'(W16 + 1));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] timeout");
    end

    // Main sequence: directed + random on the 8-bit instance, random on 16-bit.
    initial begin
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        rst16 = 1'b1; start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
        fork
            begin
                repeat (3) @(negedge clk);
                checkResetState8("reset");
                rst8 = 1'b0;
                applyStimulus(8'h5A, 8'h23, 1'b0, 0, 0);
                applyStimulus(8'h00, 8'h01, 1'b0, 0, 0);
                applyStimulus(8'h80, 8'h01, 1'b0, 0, 0);
                applyStimulus(8'h10, 8'h10, 1'b1, 0, 0);
                applyStimulus(8'h3C, 8'h71, 1'b0, 3, 0);
                applyStimulus(8'hC4, 8'h19, 1'b1, 0, 0);
                applyStimulus(8'h77, 8'h12, 1'b0, 0, 5);
                applyStimulus(8'hFF, 8'hFF, 1'b0, 0, 0);
                for (int i = 0; i < 2000; i++) begin
                    applyStimulus(W8'($urandom), W8'($urandom), 1'($urandom), 0, 0);
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                end
                repeat (3) @(negedge clk);
                checkOutput("q8_drained", 64'(q8.size()), 64'd0);
            end
            begin
                repeat (3) @(negedge clk);
                rst16 = 1'b0;
                applyStimulusWide(16'h8000, 16'h0001, 1'b0);
                applyStimulusWide(16'h0000, 16'h0000, 1'b1);
                for (int j = 0; j < 1000; j++) begin
                    applyStimulusWide(W16'($urandom), W16'($urandom), 1'($urandom));
                end
                repeat (3) @(negedge clk);
                checkOutput("q16_drained", 64'(q16.size()), 64'd0);
            end
        join
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
